// File: rtl/gcd_issuer.sv
// Request FIFO plus issue/response FSM in front of a subtract-and-swap GCD core.
// Zero-operand pairs are answered locally with rsp_err so the core is never started on them.
module gcd_issuer #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_gcd,
    output logic         rsp_err,
    output logic [15:0]  rsp_cycles,
    output logic         gcd_start,
    output logic [W-1:0] gcd_a,
    output logic [W-1:0] gcd_b,
    input  logic         gcd_ready,
    input  logic [W-1:0] gcd_out
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    req_t          fifo [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    state_t        state, state_n;
    logic [15:0]   cyc_cnt;
    logic          push, pop, load_err, load_op, capture;
    req_t          head;

    assign head      = fifo[rd_ptr];
    assign req_ready = !rst && (count != FULL);
    assign push      = req_valid && req_ready;

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        load_err = 1'b0;
        load_op  = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    if (head.a == '0 || head.b == '0) begin
                        pop      = 1'b1;
                        load_err = 1'b1;
                        state_n  = RESP;
                    end else if (gcd_ready) begin
                        pop     = 1'b1;
                        load_op = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE:     state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (gcd_ready) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP:      if (rsp_ready) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{a: req_a, b: req_b};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cyc_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_gcd    <= '0;
            rsp_err    <= 1'b0;
            rsp_cycles <= '0;
            gcd_start  <= 1'b0;
            gcd_a      <= '0;
            gcd_b      <= '0;
        end else begin
            state     <= state_n;
            gcd_start <= load_op;
            rsp_valid <= (state_n == RESP);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (load_op) begin
                gcd_a <= head.a;
                gcd_b <= head.b;
            end
            if (state == ISSUE)
                cyc_cnt <= '0;
            else if (state == WAIT_DONE && cyc_cnt != 16'hFFFF)
                cyc_cnt <= cyc_cnt + 16'd1;
            if (load_err) begin
                rsp_gcd    <= '0;
                rsp_err    <= 1'b1;
                rsp_cycles <= '0;
            end else if (capture) begin
                rsp_gcd    <= gcd_out;
                rsp_err    <= 1'b0;
                rsp_cycles <= cyc_cnt;
            end
        end
    end
endmodule

// File: tb/tb_gcd_issuer.sv
// Bench for gcd_issuer: a subtract-and-swap core model, a transaction-level scoreboard
// and directed/random request sequences.
module tb_gcd_issuer;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0, req_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_gcd;
    logic         rsp_err;
    logic [15:0]  rsp_cycles;
    logic         gcd_start;
    logic [W-1:0] gcd_a, gcd_b;
    logic         gcd_ready = 1'b1;
    logic [W-1:0] gcd_out = '0;
    logic [W-1:0] ca = '0, cb = '0;

    always #5 clk = ~clk;

    gcd_issuer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_gcd(rsp_gcd),
        .rsp_err(rsp_err), .rsp_cycles(rsp_cycles),
        .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_ready(gcd_ready), .gcd_out(gcd_out)
    );

    // Core: one subtract-or-swap step per busy cycle, done when the operands meet.
    always @(posedge clk) begin
        if (rst) begin
            gcd_ready <= 1'b1;
        end else if (gcd_start) begin
            ca <= gcd_a;
            cb <= gcd_b;
            gcd_ready <= 1'b0;
        end else if (!gcd_ready) begin
            if (ca == cb) begin
                gcd_ready <= 1'b1;
                gcd_out   <= ca;
            end else if (ca < cb) begin
                ca <= cb;
                cb <= ca;
            end else begin
                ca <= ca - cb;
            end
        end
    end

    typedef struct {bit err; int g; int c;} exp_t;
    typedef struct {int a; int b;} iss_t;
    typedef struct {string nm; bit ok; int act; int req;} chk_t;

    exp_t exp_q[$];
    iss_t iss_q[$];
    chk_t chk_q[$];
    int   nvec = 0, nerr = 0, starts = 0;
    bit   rnd = 0;

    function automatic int ref_gcd(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    function automatic int ref_cycles(input int a, input int b);
        int x = a, y = b, n = 0;
        while (n < 100000) begin
            n++;
            if (x == y) break;
            if (x < y) begin int t = x; x = y; y = t; end
            else x = x - y;
        end
        return n;
    endfunction

    function automatic void post(input string nm, input bit ok, input int act, input int req);
        chk_t k;
        k.nm = nm; k.ok = ok; k.act = act; k.req = req;
        chk_q.push_back(k);
    endfunction

    function automatic void chk(input string nm, input bit ok, input int act, input int req);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Single scoreboard process: every counted comparison is made here.
    chk_t kk;
    exp_t ee;
    iss_t ie;
    bit   hold = 0;
    int   pg, pe, pc;
    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            kk = chk_q.pop_front();
            chk(kk.nm, kk.ok, kk.act, kk.req);
        end
        if (rst) begin
            hold = 0;
        end else begin
            if (gcd_start) begin
                starts++;
                chk("start_while_busy", gcd_ready == 1'b1, int'(gcd_ready), 1);
                if (iss_q.size() == 0) chk("spurious_start", 1'b0, int'(gcd_a), 0);
                else begin
                    ie = iss_q.pop_front();
                    chk("gcd_a", int'(gcd_a) == ie.a, int'(gcd_a), ie.a);
                    chk("gcd_b", int'(gcd_b) == ie.b, int'(gcd_b), ie.b);
                end
            end
            if (rsp_valid) begin
                if (hold)
                    chk("rsp_stable", int'(rsp_gcd) == pg && int'(rsp_err) == pe
                        && int'(rsp_cycles) == pc, int'(rsp_gcd), pg);
                if (rsp_ready) begin
                    hold = 0;
                    if (exp_q.size() == 0) chk("spurious_rsp", 1'b0, int'(rsp_gcd), 0);
                    else begin
                        ee = exp_q.pop_front();
                        chk("rsp_err", int'(rsp_err) == int'(ee.err), int'(rsp_err), int'(ee.err));
                        chk("rsp_gcd", int'(rsp_gcd) == ee.g, int'(rsp_gcd), ee.g);
                        chk("rsp_cycles", int'(rsp_cycles) == ee.c, int'(rsp_cycles), ee.c);
                    end
                end else begin
                    hold = 1;
                    pg = int'(rsp_gcd); pe = int'(rsp_err); pc = int'(rsp_cycles);
                end
            end else begin
                hold = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (rnd) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one pair until accepted; when lit is set the hand value is the expectation.
    task automatic push(input int a, input int b, input bit lit, input int lg, input int lc);
        exp_t e;
        iss_t s;
        bit   done = 0;
        req_valid = 1'b1; req_a = W'(a); req_b = W'(b);
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
                e.err = (a == 0 || b == 0);
                e.g   = e.err ? 0 : ref_gcd(a, b);
                e.c   = e.err ? 0 : ref_cycles(a, b);
                if (lit) begin
                    post("model_pin", e.g == lg && e.c == lc, e.g * 1000 + e.c, lg * 1000 + lc);
                    e.g = lg; e.c = lc;
                end
                exp_q.push_back(e);
                post("fifo_bound", exp_q.size() <= DEPTH + 1, exp_q.size(), DEPTH + 1);
                if (!e.err) begin
                    s.a = a; s.b = b;
                    iss_q.push_back(s);
                end
            end
            tick();
        end
        req_valid = 1'b0;
        if (!done) post("push_timeout", 1'b0, a, b);
    endtask

    task automatic drain();
        for (int t = 0; t < 5000 && exp_q.size() != 0; t++) tick();
        post("drain", exp_q.size() == 0, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        int s0, bad;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        post("rst_req_ready", req_ready == 1'b0, int'(req_ready), 0);
        post("rst_rsp_valid", rsp_valid == 1'b0, int'(rsp_valid), 0);
        post("rst_gcd_start", gcd_start == 1'b0, int'(gcd_start), 0);
        post("rst_rsp_data", rsp_gcd == '0 && rsp_cycles == '0 && !rsp_err,
             int'(rsp_gcd) + int'(rsp_cycles), 0);
        @(posedge clk); #1 rst = 1'b0;

        s0 = starts;
        push(48, 18, 1, 6, 7);
        drain();
        post("t1_starts", starts - s0 == 1, starts - s0, 1);

        s0 = starts;
        push(7, 7, 1, 7, 1);
        drain();
        post("t2_starts", starts - s0 == 1, starts - s0, 1);

        s0 = starts;
        push(0, 5, 1, 0, 0);
        push(5, 0, 1, 0, 0);
        drain();
        post("t3_starts", starts - s0 == 0, starts - s0, 0);

        rsp_ready = 1'b0;
        push(12, 8, 1, 4, 4);
        push(9, 6, 1, 3, 4);
        push(35, 14, 1, 7, 5);
        push(17, 5, 1, 1, 9);
        push(100, 75, 1, 25, 5);
        req_valid = 1'b1; req_a = 8'd21; req_b = 8'd6;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 4 == 3) post("t4_full", req_ready == 1'b0, int'(req_ready), 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        push(21, 6, 1, 3, 6);
        drain();

        s0 = starts;
        push(255, 1, 1, 1, 255);
        for (int t = 0; t < 50 && starts == s0; t++) tick();
        post("t5_started", starts != s0, starts - s0, 1);
        repeat (5) tick();
        rst = 1'b1;
        exp_q.delete();
        iss_q.delete();
        @(negedge clk);
        post("t5_rst_req_ready", req_ready == 1'b0, int'(req_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        post("t5_rsp_valid", rsp_valid == 1'b0, int'(rsp_valid), 0);
        post("t5_outs_zero", rsp_gcd == '0 && !rsp_err && rsp_cycles == '0 && !gcd_start
             && gcd_a == '0 && gcd_b == '0, int'(gcd_a) + int'(rsp_cycles), 0);
        post("t5_req_ready", req_ready == 1'b1, int'(req_ready), 1);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid || gcd_start) bad++;
        end
        post("t5_quiet", bad == 0, bad, 0);
        @(posedge clk); #1;
        push(20, 8, 1, 4, 5);
        drain();

        rnd = 1;
        for (int i = 0; i < 32; i++)
            push(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), 0, 0, 0);
        drain();
        rnd = 0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
